// File: rtl/tug_war_ctrl_pkg.sv
// Shared types for the tug-of-war controller: FSM states, score width, score helper.
// Pure declarations, no timing or flow control.
package tow_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        WIN_H = 3'd2,
        WIN_C = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam int SCORE_W = 3;

    // Scores stick at the top of their range instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == {SCORE_W{1'b1}}) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/tug_war_ctrl_if.sv
// Board-side signal bundle of the tug-of-war controller (keys, comparator, LEDs, scores).
// master = controller, slave = board or bench; no handshake, levels and strobes only.
interface tug_war_ctrl_if
    import tow_pkg::*;
#(
    parameter int HALF = 4
);
    logic               key_human;
    logic               cpu_press;
    logic               lfsr_step;
    logic [2*HALF:0]    leds;
    logic               win_human;
    logic               win_cpu;
    logic [SCORE_W-1:0] score_human;
    logic [SCORE_W-1:0] score_cpu;
    logic               game_over;

    modport master (
        input  key_human, cpu_press,
        output lfsr_step, leds, win_human, win_cpu, score_human, score_cpu, game_over
    );

    modport slave (
        output key_human, cpu_press,
        input  lfsr_step, leds, win_human, win_cpu, score_human, score_cpu, game_over
    );
endinterface

// File: rtl/tug_war_ctrl_key_edge.sv
// Async key to 1-cycle pulse: 2-flop synchronizer plus rising-edge detect.
// Pulse is valid 2 cycles after the key rises (acted on at the 3rd edge); a held key gives one pulse.
module key_edge (
    input  logic Clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);
    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge Clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;
endmodule

// File: rtl/tug_war_ctrl.sv
// Round/game controller for human-vs-computer tug-of-war: paces the cpu, moves the light, scores rounds.
// Outputs decoded from registered state only; no backpressure, events are acted on the cycle they occur.
module tug_war_ctrl
    import tow_pkg::*;
#(
    parameter int HALF      = 4,
    parameter int TICK_DIV  = 16,
    parameter int ROUND_GAP = 8,
    parameter int MAX_SCORE = 7
) (
    input  logic           Clock,
    input  logic           reset,
    tug_war_ctrl_if.master bus
);
    localparam int POS_W  = $clog2(2*HALF+1);
    localparam int TCNT_W = $clog2(TICK_DIV);
    localparam int GAP_W  = $clog2(ROUND_GAP+1);

    localparam logic [POS_W-1:0]   POS_MID  = POS_W'(HALF);
    localparam logic [POS_W-1:0]   POS_MAX  = POS_W'(2*HALF);
    localparam logic [TCNT_W-1:0]  TLAST    = TCNT_W'(TICK_DIV-1);
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(ROUND_GAP-1);
    localparam logic [SCORE_W-1:0] MAX_S    = SCORE_W'(MAX_SCORE);

    state_t             state, state_n;
    logic [POS_W-1:0]   pos, pos_n;
    logic [TCNT_W-1:0]  cnt, cnt_n;
    logic [GAP_W-1:0]   gap, gap_n;
    logic [SCORE_W-1:0] sh, sh_n;
    logic [SCORE_W-1:0] sc, sc_n;

    logic h_evt;
    logic tick;
    logic c_evt;

    key_edge u_key_edge (
        .Clock (Clock),
        .reset (reset),
        .raw   (bus.key_human),
        .pulse (h_evt)
    );

    assign tick  = (state == PLAY) && (cnt == TLAST);
    assign c_evt = tick & bus.cpu_press;

    always_ff @(posedge Clock) begin
        if (reset) begin
            state <= IDLE;
            pos   <= POS_MID;
            cnt   <= '0;
            gap   <= '0;
            sh    <= '0;
            sc    <= '0;
        end else begin
            state <= state_n;
            pos   <= pos_n;
            cnt   <= cnt_n;
            gap   <= gap_n;
            sh    <= sh_n;
            sc    <= sc_n;
        end
    end

    always_comb begin
        state_n = state;
        pos_n   = pos;
        cnt_n   = '0;
        gap_n   = gap;
        sh_n    = sh;
        sc_n    = sc;
        case (state)
            IDLE: begin
                pos_n = POS_MID;
                // The starting press only launches the round; it does not pull the light.
                if (h_evt) begin
                    state_n = PLAY;
                end
            end
            PLAY: begin
                cnt_n = tick ? '0 : cnt + TCNT_W'(1);
                // Simultaneous human and cpu events cancel each other.
                if (h_evt && !c_evt) begin
                    if (pos == '0) begin
                        state_n = WIN_H;
                        sh_n    = sat_inc(sh);
                        gap_n   = GAP_LOAD;
                        cnt_n   = '0;
                    end else begin
                        pos_n = pos - POS_W'(1);
                    end
                end else if (c_evt && !h_evt) begin
                    if (pos == POS_MAX) begin
                        state_n = WIN_C;
                        sc_n    = sat_inc(sc);
                        gap_n   = GAP_LOAD;
                        cnt_n   = '0;
                    end else begin
                        pos_n = pos + POS_W'(1);
                    end
                end
            end
            WIN_H, WIN_C: begin
                if (gap == '0) begin
                    if (sh == MAX_S || sc == MAX_S) begin
                        state_n = OVER;
                    end else begin
                        state_n = PLAY;
                        pos_n   = POS_MID;
                    end
                end else begin
                    gap_n = gap - GAP_W'(1);
                end
            end
            OVER: begin
                state_n = OVER;
            end
            default: begin
                state_n = IDLE;
                pos_n   = POS_MID;
            end
        endcase
    end

    always_comb begin
        bus.leds      = '0;
        bus.leds[pos] = 1'b1;
    end

    assign bus.lfsr_step   = tick;
    assign bus.win_human   = (state == WIN_H);
    assign bus.win_cpu     = (state == WIN_C);
    assign bus.game_over   = (state == OVER);
    assign bus.score_human = sh;
    assign bus.score_cpu   = sc;
endmodule

// File: tb/tb_tug_war_ctrl.sv
// Directed bench for tug_war_ctrl with HALF=2, TICK_DIV=4, ROUND_GAP=3, MAX_SCORE=2.
module tb_tug_war_ctrl;
    import tow_pkg::*;

    logic Clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    tug_war_ctrl_if #(.HALF(2)) bus ();

    tug_war_ctrl #(
        .HALF      (2),
        .TICK_DIV  (4),
        .ROUND_GAP (3),
        .MAX_SCORE (2)
    ) dut (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Key high for one cycle; returns right after the edge that acts on the pulse.
    task automatic press();
        bus.key_human = 1'b1;
        step(1);
        bus.key_human = 1'b0;
        step(2);
    endtask

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        while (bus.lfsr_step !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        chk(tag, 32'(n < 40), 32'd1);
    endtask

    function automatic logic [31:0] st();
        return 32'(dut.state);
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.key_human = 1'b0;
        bus.cpu_press = 1'b0;
        step(2);

        // 1: reset state, start, tick pacing
        chk("rst_state", st(), 32'(IDLE));
        chk("rst_leds", 32'(bus.leds), 32'b00100);
        chk("rst_sh", 32'(bus.score_human), 0);
        chk("rst_sc", 32'(bus.score_cpu), 0);
        chk("rst_over", 32'(bus.game_over), 0);
        chk("rst_step", 32'(bus.lfsr_step), 0);
        reset = 1'b0;
        bus.key_human = 1'b1;
        step(1);
        bus.key_human = 1'b0;
        step(1);
        chk("start_not_yet", st(), 32'(IDLE));
        step(1);
        chk("start_play", st(), 32'(PLAY));
        chk("start_leds", 32'(bus.leds), 32'b00100);
        chk("step_c0", 32'(bus.lfsr_step), 0);
        step(3);
        chk("step_c3", 32'(bus.lfsr_step), 1);
        step(1);
        chk("step_c4", 32'(bus.lfsr_step), 0);
        step(3);
        chk("step_c7", 32'(bus.lfsr_step), 1);

        // 2: human walks light to its end and wins
        press();
        chk("h_mv1", 32'(bus.leds), 32'b00010);
        press();
        chk("h_mv2", 32'(bus.leds), 32'b00001);
        press();
        chk("winh_c1", 32'(bus.win_human), 1);
        chk("winh_score", 32'(bus.score_human), 1);
        chk("winh_leds", 32'(bus.leds), 32'b00001);
        step(1);
        chk("winh_c2", 32'(bus.win_human), 1);
        step(1);
        chk("winh_c3", 32'(bus.win_human), 1);
        step(1);
        chk("winh_end", 32'(bus.win_human), 0);
        chk("winh_recentre", 32'(bus.leds), 32'b00100);
        chk("winh_play", st(), 32'(PLAY));

        // 3: cpu pulls one step per tick and wins
        bus.cpu_press = 1'b1;
        wait_tick("c_tick1");
        step(1);
        chk("c_mv1", 32'(bus.leds), 32'b01000);
        wait_tick("c_tick2");
        step(1);
        chk("c_mv2", 32'(bus.leds), 32'b10000);
        wait_tick("c_tick3");
        step(1);
        bus.cpu_press = 1'b0;
        chk("winc_flag", 32'(bus.win_cpu), 1);
        chk("winc_score", 32'(bus.score_cpu), 1);
        chk("winc_leds", 32'(bus.leds), 32'b10000);
        step(3);
        chk("winc_end", 32'(bus.win_cpu), 0);
        chk("winc_recentre", 32'(bus.leds), 32'b00100);

        // 4: human edge coincides with a cpu tick -> cancel
        step(1);
        bus.key_human = 1'b1;
        bus.cpu_press = 1'b1;
        step(1);
        bus.key_human = 1'b0;
        step(1);
        chk("tie_tick", 32'(bus.lfsr_step), 1);
        step(1);
        bus.cpu_press = 1'b0;
        chk("tie_leds", 32'(bus.leds), 32'b00100);
        chk("tie_sh", 32'(bus.score_human), 1);
        chk("tie_sc", 32'(bus.score_cpu), 1);
        chk("tie_nowin", 32'(bus.win_human | bus.win_cpu), 0);

        // 6: held key gives exactly one move
        bus.key_human = 1'b1;
        step(20);
        bus.key_human = 1'b0;
        step(3);
        chk("held_one_move", 32'(bus.leds), 32'b00010);

        // 5: human takes the match
        press();
        chk("m_mv", 32'(bus.leds), 32'b00001);
        press();
        chk("m_win", 32'(bus.win_human), 1);
        chk("m_score", 32'(bus.score_human), 2);
        step(3);
        chk("over_flag", 32'(bus.game_over), 1);
        chk("over_state", st(), 32'(OVER));
        chk("over_leds", 32'(bus.leds), 32'b00001);
        chk("over_nowin", 32'(bus.win_human), 0);
        bus.cpu_press = 1'b1;
        press();
        press();
        step(8);
        chk("over_hold_leds", 32'(bus.leds), 32'b00001);
        chk("over_hold_sh", 32'(bus.score_human), 2);
        chk("over_hold_sc", 32'(bus.score_cpu), 1);
        chk("over_hold_flag", 32'(bus.game_over), 1);
        chk("over_no_step", 32'(bus.lfsr_step), 0);
        bus.cpu_press = 1'b0;

        // 7: reset out of OVER, then during a WIN_H hold
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst2_over", 32'(bus.game_over), 0);
        chk("rst2_state", st(), 32'(IDLE));
        press();
        chk("rst2_play", st(), 32'(PLAY));
        press();
        press();
        press();
        chk("rst3_inwin", 32'(bus.win_human), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst3_state", st(), 32'(IDLE));
        chk("rst3_sh", 32'(bus.score_human), 0);
        chk("rst3_sc", 32'(bus.score_cpu), 0);
        chk("rst3_leds", 32'(bus.leds), 32'b00100);
        chk("rst3_win", 32'(bus.win_human), 0);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
